// File: rtl/lenet_image_loader.sv
// lenet_image_loader
//   Collects a raster-ordered pixel stream into a full IMG_DIM x IMG_DIM
//   frame buffer, then holds the frame for a downstream accelerator until
//   it is consumed.
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   pix_data/valid/last pixel stream in; pix_last marks the final pixel
//   pix_ready           high while filling (pixel accepted on valid & ready)
//   image[row][col]     assembled frame, valid while frame_valid is high
//   frame_valid/ready   frame handoff; consumed on frame_valid & frame_ready
//   frame_err           one-cycle pulse when pix_last disagrees with position
//   frame_cnt           number of frames handed off, wraps at 16 bits
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_FILL | accepting pixels into image, frame_valid low
// ST_FULL | complete frame held stable, waiting for frame_ready
module lenet_image_loader #(
  parameter int BITWIDTH = 32,
  parameter int IMG_DIM  = 28
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BITWIDTH-1:0] pix_data,
  input  logic                pix_valid,
  input  logic                pix_last,
  output logic                pix_ready,
  output logic [BITWIDTH-1:0] image [IMG_DIM][IMG_DIM],
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                frame_err,
  output logic [15:0]         frame_cnt
);

  localparam int               IDX_W    = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(IMG_DIM - 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    row_q, row_d;
  logic [IDX_W-1:0]    col_q, col_d;
  logic                frame_err_q, frame_err_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [BITWIDTH-1:0] image_q [IMG_DIM][IMG_DIM];

  logic accept;
  logic handoff;
  logic at_last_pix;

  assign accept      = pix_valid & pix_ready;
  assign handoff     = frame_valid & frame_ready;
  assign at_last_pix = (row_q == LAST_POS) && (col_q == LAST_POS);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (accept && at_last_pix) state_d = ST_FULL;
      ST_FULL: if (handoff)               state_d = ST_FILL;
      default:                            state_d = ST_FILL;
    endcase
  end

  always_comb begin
    pix_ready   = 1'b0;
    frame_valid = 1'b0;
    case (state_q)
      ST_FILL: pix_ready   = 1'b1;
      ST_FULL: frame_valid = 1'b1;
      default: pix_ready   = 1'b1;
    endcase
  end

  // ------------------------------------------------- position / status
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (accept) begin
      if (at_last_pix) begin
        // frame completes by position; a missing pix_last is only flagged
        row_d       = '0;
        col_d       = '0;
        frame_err_d = ~pix_last;
      end else if (pix_last) begin
        // early pix_last: restart the frame, partial data is abandoned
        row_d       = '0;
        col_d       = '0;
        frame_err_d = 1'b1;
      end else if (col_q == LAST_POS) begin
        col_d = '0;
        row_d = row_q + IDX_W'(1);
      end else begin
        col_d = col_q + IDX_W'(1);
      end
    end
    if (handoff) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // ------------------------------------------------------ frame buffer
  // Entries not yet overwritten keep the previous frame's data; only the
  // addressed entry is written per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < IMG_DIM; r++) begin
        for (int c = 0; c < IMG_DIM; c++) begin
          image_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      image_q[row_q][col_q] <= pix_data;
    end
  end

  assign image     = image_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_lenet_image_loader.sv
// Testbench for lenet_image_loader: directed scenarios with random pixel
// data, checked against a frame-level reference model.
module tb_lenet_image_loader;

  localparam int BW   = 32;
  localparam int DIM  = 28;
  localparam int NPIX = DIM * DIM;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_last;
  logic          pix_ready;
  logic [BW-1:0] image [DIM][DIM];
  logic          frame_valid;
  logic          frame_ready;
  logic          frame_err;
  logic [15:0]   frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: frame buffer, next pixel index, full flag, counters
  logic [BW-1:0] m_img [DIM][DIM];
  int            m_idx;
  bit            m_full;
  bit            m_err;
  logic [15:0]   m_cnt;
  int            dut_acc;

  lenet_image_loader #(.BITWIDTH(BW), .IMG_DIM(DIM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .image      (image),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m_img[r][c] = '0;
    m_idx  = 0;
    m_full = 0;
    m_err  = 0;
    m_cnt  = '0;
  endtask

  function automatic int img_diff();
    int n = 0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        if (image[r][c] !== m_img[r][c]) n++;
    return n;
  endfunction

  function automatic int nominal_diff();
    int n = 0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        if (image[r][c] !== BW'(r * DIM + c + 1)) n++;
    return n;
  endfunction

  // Drive one cycle of inputs (called just after a rising edge), advance the
  // model, and return 1 time unit after the next rising edge.
  task automatic cycle(input logic v, input logic [BW-1:0] d, input logic l,
                       input logic fr);
    pix_valid   = v;
    pix_data    = d;
    pix_last    = l;
    frame_ready = fr;
    if (v && pix_ready) dut_acc++;
    m_err = 0;
    if (!m_full && v) begin
      m_img[m_idx / DIM][m_idx % DIM] = d;
      if (m_idx == NPIX - 1) begin
        m_full = 1;
        m_err  = !l;
        m_idx  = 0;
      end else if (l) begin
        m_err = 1;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end else if (m_full && fr) begin
      m_full = 0;
      m_cnt  = m_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; pix_valid = 0; pix_data = '0; pix_last = 0; frame_ready = 0;
    dut_acc = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #10;
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fv: got %0b want 0", frame_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", frame_err); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (img_diff() !== 0) begin n_bad++; $display("FAIL reset_img: %0d entries nonzero, want 0", img_diff()); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %0b want 1", pix_ready); end
  endtask

  task automatic test_nominal();
    for (int i = 0; i < NPIX; i++) begin
      cycle(1'b1, BW'(i + 1), i == NPIX - 1, 1'b0);
      if (i == NPIX - 2) begin
        n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL nom_fv_early: got %0b want 0", frame_valid); end
      end
    end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL nom_fv: got %0b want 1", frame_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL nom_err: got %0b want 0", frame_err); end
    n_cmp++; if (image[0][0] !== 32'd1) begin n_bad++; $display("FAIL nom_00: got %0d want 1", image[0][0]); end
    n_cmp++; if (image[0][27] !== 32'd28) begin n_bad++; $display("FAIL nom_0_27: got %0d want 28", image[0][27]); end
    n_cmp++; if (image[1][0] !== 32'd29) begin n_bad++; $display("FAIL nom_1_0: got %0d want 29", image[1][0]); end
    n_cmp++; if (image[27][27] !== 32'd784) begin n_bad++; $display("FAIL nom_27_27: got %0d want 784", image[27][27]); end
    n_cmp++; if (nominal_diff() !== 0) begin n_bad++; $display("FAIL nom_img: %0d entries differ, want 0", nominal_diff()); end
    cycle(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("FAIL nom_rdy: got %0b want 0", pix_ready); end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL nom_fv_hold: got %0b want 1", frame_valid); end
  endtask

  task automatic test_hold_handoff();
    int acc0 = dut_acc;
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    n_cmp++; if (dut_acc - acc0 !== 0) begin n_bad++; $display("FAIL hold_acc: got %0d accepts want 0", dut_acc - acc0); end
    n_cmp++; if (img_diff() !== 0) begin n_bad++; $display("FAIL hold_img: %0d entries differ, want 0", img_diff()); end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL hold_fv: got %0b want 1", frame_valid); end
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL hand_fv: got %0b want 0", frame_valid); end
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL hand_rdy: got %0b want 1", pix_ready); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL hand_cnt: got %0d want 1", frame_cnt); end
    // frame_ready while filling must not bump the count
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if (frame_cnt !== m_cnt) begin n_bad++; $display("FAIL fill_ready_cnt: got %0d want %0d", frame_cnt, m_cnt); end
  endtask

  task automatic test_early_last();
    logic [BW-1:0] d;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, $urandom, i == 99, 1'b0);
      if (i == 98) begin
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL early_err_pre: got %0b want 0", frame_err); end
      end
    end
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL early_err: got %0b want 1", frame_err); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL early_fv: got %0b want 0", frame_valid); end
    cycle(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL early_err_len: got %0b want 0", frame_err); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL early_fv2: got %0b want 0", frame_valid); end
    d = $urandom;
    cycle(1'b1, d, 1'b1, 1'b0);
    n_cmp++; if (image[0][0] !== d) begin n_bad++; $display("FAIL early_restart: got %0h want %0h", image[0][0], d); end
    n_cmp++; if (frame_err !== 1'(m_err)) begin n_bad++; $display("FAIL early_err2: got %0b want %0b", frame_err, m_err); end
    n_cmp++; if (img_diff() !== 0) begin n_bad++; $display("FAIL early_img: %0d entries differ, want 0", img_diff()); end
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_missing_last();
    for (int i = 0; i < NPIX; i++) begin
      cycle(1'b1, $urandom, 1'b0, 1'b0);
      if (i == NPIX - 2) begin
        n_cmp++; if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
          n_bad++; $display("FAIL miss_pre: got fv=%0b err=%0b want 0 0", frame_valid, frame_err);
        end
      end
    end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL miss_fv: got %0b want 1", frame_valid); end
    n_cmp++; if (frame_err !== 1'(m_err)) begin n_bad++; $display("FAIL miss_err: got %0b want %0b", frame_err, m_err); end
    n_cmp++; if (img_diff() !== 0) begin n_bad++; $display("FAIL miss_img: %0d entries differ, want 0", img_diff()); end
    cycle(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL miss_err_len: got %0b want 0", frame_err); end
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if (frame_cnt !== m_cnt) begin n_bad++; $display("FAIL miss_cnt: got %0d want %0d", frame_cnt, m_cnt); end
  endtask

  task automatic async_reset(input string tag);
    pix_valid = 0; frame_ready = 0; pix_last = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL %s_fv: got %0b want 0", tag, frame_valid); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL %s_cnt: got %0d want 0", tag, frame_cnt); end
    n_cmp++; if (img_diff() !== 0) begin n_bad++; $display("FAIL %s_img: %0d entries nonzero, want 0", tag, img_diff()); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL %s_rdy: got %0b want 1", tag, pix_ready); end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] d;
    for (int i = 0; i < 300; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    async_reset("rst_mid");
    d = $urandom;
    cycle(1'b1, d, 1'b0, 1'b0);
    n_cmp++; if (image[0][0] !== d) begin n_bad++; $display("FAIL rst_first_pix: got %0h want %0h", image[0][0], d); end
    for (int i = 1; i < NPIX; i++) cycle(1'b1, $urandom, i == NPIX - 1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < NPIX; i++) cycle(1'b1, $urandom, i == NPIX - 1, 1'b0);
    n_cmp++; if (frame_valid !== 1'b1 || frame_cnt !== m_cnt) begin
      n_bad++; $display("FAIL rst_pre_full: got fv=%0b cnt=%0d want 1 %0d", frame_valid, frame_cnt, m_cnt);
    end
    async_reset("rst_full");
  endtask

  task automatic test_backpressure();
    int  acc0 = dut_acc;
    int  k    = 0;
    int  cyc  = 0;
    logic v;
    while (!m_full && cyc < 20000) begin
      v = 1'($urandom_range(0, 1));
      cycle(v, BW'(k + 1), k == NPIX - 1, 1'b0);
      if (v) k++;
      cyc++;
    end
    n_cmp++; if (!m_full) begin n_bad++; $display("FAIL bp_timeout: got %0d accepts in %0d cycles want %0d", k, cyc, NPIX); end
    n_cmp++; if (dut_acc - acc0 !== NPIX) begin n_bad++; $display("FAIL bp_acc: got %0d want %0d", dut_acc - acc0, NPIX); end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL bp_fv: got %0b want 1", frame_valid); end
    n_cmp++; if (nominal_diff() !== 0) begin n_bad++; $display("FAIL bp_img: %0d entries differ from nominal, want 0", nominal_diff()); end
    n_cmp++; if (img_diff() !== 0) begin n_bad++; $display("FAIL bp_model: %0d entries differ, want 0", img_diff()); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_hold_handoff();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
